mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Shares one single-port, byte-wide, synchronous-read data memory between two requesters: instruction fetch (IF) and the load/store stage (D).
- Arbitrates between the two requesters, then performs each access as a sequence of single-byte memory cycles.
- Assembles little-endian read data with zero or sign extension and returns it with a one-cycle done pulse.
- Sits between the pipeline and the byte memory array; the pipeline stalls on busy.

Parameters:
- AW, 12, memory byte-address width (4096 bytes).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  fetch request; always a 32-bit word read
- if_addr  input  32  fetch byte address; low AW bits used
- if_gnt  output  1  high while a fetch transaction is in progress
- if_done  output  1  one-cycle pulse; if_rdata valid in the same cycle
- if_rdata  output  32  fetched word
- d_req  input  1  data request
- d_we  input  1  1 = store, 0 = load
- d_addr  input  32  data byte address; low AW bits used
- d_wdata  input  32  store data
- d_length  input  2  00 = word, 01 = byte, 10 = half, 11 = word
- d_sign  input  1  sign-extend load result
- d_gnt  output  1  high while a data transaction is in progress
- d_done  output  1  one-cycle pulse; d_rdata valid in the same cycle for loads
- d_rdata  output  32  load result
- busy  output  1  high in every state except IDLE
- mem_addr  output  AW  byte address to memory
- mem_wdata  output  8  write byte
- mem_we  output  1  write strobe; byte written at the clk edge
- mem_re  output  1  read strobe; mem_rdata is valid in the following cycle
- mem_rdata  input  8  read byte

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0 immediately (if_rdata, d_rdata, strobes and pulses included).
  - The round-robin pointer is set to favour D.
- Byte count N: 4 for length 00 or 11, 1 for 01, 2 for 10. A fetch always has N = 4.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled here only.
  - If exactly one req is high, that requester is granted.
  - If both are high, the requester not granted last is granted. The first tie after reset goes to D.
  - On grant, latch address, wdata, length, sign, we and the winner ID, clear the byte counter k, go to ISSUE, and assert the winner's gnt.
- ISSUE, N cycles, k = 0..N-1:
  - mem_addr = (base + k) mod 2^AW; wrap-around is permitted.
  - Store: mem_we = 1, mem_wdata = wdata byte k (little-endian).
  - Load or fetch: mem_re = 1.
  - After the last byte, a store goes to RESP and a load goes to WAIT.
- Read capture: mem_rdata is captured into byte lane k-1 at the end of the ISSUE cycle for k ≥ 1. The last byte is captured at the end of WAIT.
- WAIT, 1 cycle, loads only:
  - Strobes are low.
  - Capture the final byte, apply extension, go to RESP.
- Extension:
  - Byte: bits [31:8] = sign ? byte0[7] : 0.
  - Half: bits [31:16] = sign ? byte1[7] : 0.
  - Word: no extension.
  - Fetch: always unsigned.
- RESP, 1 cycle:
  - The winner's done = 1.
  - Its rdata register is updated; it holds until the next load or fetch by that same requester. Stores leave d_rdata unchanged.
  - gnt drops, update the round-robin pointer, return to IDLE.
- Latency from the request-sampling edge to done:
  - Read: N + 2 cycles (word load 6, byte load 3).
  - Store: N + 1 cycles (word store 5).
- Requester rules:
  - Hold req and request fields stable until done is seen, then deassert req on that same edge.
  - If req is still high in the following IDLE cycle, a new transaction starts.
- Strobes: mem_we and mem_re are never high together, and never outside ISSUE.
- Mid-transaction changes: changes on the non-granted requester's inputs, or on the granted requester's inputs after grant, do not affect the transaction in progress.
- Reset mid-operation:
  - The transaction is abandoned and no done pulse is generated.
  - Memory bytes already written stay written.
- Throughput: back-to-back alternating grants with both requesters active; no idle cycle other than the mandatory IDLE sample cycle.

Test Plan:
- D word store 0xDEADBEEF @0x010, then D word load @0x010:
  - During the store, memory bytes 0x010..0x013 receive EF, BE, AD, DE.
  - The load returns d_rdata = 0xDEADBEEF.
  - d_done arrives 5 cycles after the store request and 6 cycles after the load request.
- Byte 0x80 at @0x020:
  - Byte load with sign = 1 → 0xFFFFFF80.
  - Byte load with sign = 0 → 0x00000080.
  - Each completes in 3 cycles.
- Half load @0x030 holding bytes 01, 80:
  - sign = 1 → 0xFFFF8001.
  - sign = 0 → 0x00008001.
- if_req and d_req both held high from reset:
  - Grants go D, IF, D, IF.
  - busy never drops for more than the one IDLE cycle between transactions.
  - mem_we and mem_re are never high together.
- D word store 0x11223344 @0xFFE (AW = 12): memory bytes 0xFFE, 0xFFF, 0x000, 0x001 receive 44, 33, 22, 11.
- rst asserted during the 3rd ISSUE cycle of a word store:
  - Outputs go to 0 immediately and the FSM is in IDLE.
  - No d_done is generated.
  - Bytes 0 and 1 are written; bytes 2 and 3 are untouched.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares one byte-wide synchronous-read memory
// between instruction fetch and load/store, one byte per cycle.
module mem_port_sequencer #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [1:0]    d_length,
    input  logic          d_sign,
    output logic          d_gnt,
    output logic          d_done,
    output logic [31:0]   d_rdata,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          is_if_q, is_if_d;
    logic          we_q, we_d;
    logic          sign_q, sign_d;
    logic [1:0]    len_q, len_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    k_q, k_d;
    logic [23:0]   lane_q, lane_d;
    logic          last_if_q, last_if_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          pick_if;
    logic [31:0]   res;
    logic [1:0]    last_k;
    logic          issue;
    logic [AW-1:0] addr_k;
    logic [31:0]   wsh;
    logic          unused_bits;

    assign last_k = (len_q == 2'b01) ? 2'd0 :
                    (len_q == 2'b10) ? 2'd1 : 2'd3;
    assign issue  = (state_q == ISSUE);
    assign addr_k = base_q + {{(AW-2){1'b0}}, k_q};
    assign wsh    = wdata_q >> {k_q, 3'b000};

    assign busy      = (state_q != IDLE);
    assign mem_we    = issue & we_q;
    assign mem_re    = issue & ~we_q;
    assign mem_addr  = issue ? addr_k : '0;
    assign mem_wdata = mem_we ? wsh[7:0] : 8'h00;
    assign if_gnt    = busy & is_if_q;
    assign d_gnt     = busy & ~is_if_q;
    assign if_done   = (state_q == RESP) & is_if_q;
    assign d_done    = (state_q == RESP) & ~is_if_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign unused_bits = ^{if_addr[31:AW], d_addr[31:AW], wsh[31:8]};

    // Next-state: arbitration, byte sequencing, read assembly
    always_comb begin
        state_d    = state_q;
        is_if_d    = is_if_q;
        we_d       = we_q;
        sign_d     = sign_q;
        len_d      = len_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        k_d        = k_q;
        lane_d     = lane_q;
        last_if_d  = last_if_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        pick_if    = 1'b0;
        res        = '0;
        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    pick_if = if_req & (~d_req | ~last_if_q);
                    is_if_d = pick_if;
                    k_d     = 2'd0;
                    state_d = ISSUE;
                    if (pick_if) begin
                        we_d    = 1'b0;
                        sign_d  = 1'b0;
                        len_d   = 2'b00;
                        base_d  = if_addr[AW-1:0];
                        wdata_d = '0;
                    end else begin
                        we_d    = d_we;
                        sign_d  = d_sign;
                        len_d   = d_length;
                        base_d  = d_addr[AW-1:0];
                        wdata_d = d_wdata;
                    end
                end
            end
            ISSUE: begin
                if (!we_q) begin
                    case (k_q)
                        2'd1:    lane_d[7:0]   = mem_rdata;
                        2'd2:    lane_d[15:8]  = mem_rdata;
                        2'd3:    lane_d[23:16] = mem_rdata;
                        default: ;
                    endcase
                end
                if (k_q == last_k) begin
                    state_d = we_q ? RESP : WAIT;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            WAIT: begin
                case (len_q)
                    2'b01:
                        res = {{24{sign_q & mem_rdata[7]}}, mem_rdata};
                    2'b10:
                        res = {{16{sign_q & mem_rdata[7]}},
                               mem_rdata, lane_q[7:0]};
                    default:
                        res = {mem_rdata, lane_q};
                endcase
                if (is_if_q) begin
                    if_rdata_d = res;
                end else begin
                    d_rdata_d = res;
                end
                state_d = RESP;
            end
            RESP: begin
                last_if_d = is_if_q;
                state_d   = IDLE;
            end
        endcase
    end

    // State and datapath registers; tie-break initially favours D
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            is_if_q    <= 1'b0;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            len_q      <= 2'b00;
            base_q     <= '0;
            wdata_q    <= '0;
            k_q        <= 2'd0;
            lane_q     <= '0;
            last_if_q  <= 1'b1;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_if_q    <= is_if_d;
            we_q       <= we_d;
            sign_q     <= sign_d;
            len_q      <= len_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            k_q        <= k_d;
            lane_q     <= lane_d;
            last_if_q  <= last_if_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer: transaction-level model plus per-cycle
// compare of every DUT output, directed cases and random traffic.
module tb_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_length = '0;
    logic        d_sign = 1'b0;
    logic        d_gnt, d_done;
    logic [31:0] d_rdata;
    logic        busy;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata = '0;

    int total = 0;
    int bad = 0;

    logic [7:0] ram    [4096];
    logic [7:0] shadow [4096];

    mem_port_sequencer #(.AW(12)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_length(d_length), .d_sign(d_sign),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // byte memory behind the port
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // ---------------- transaction-level reference model -------------
    bit          m_busy = 0, m_is_if = 0, m_we = 0, m_last_if = 1;
    int          m_n = 0, m_t = 0;
    logic [11:0] m_base = '0;
    logic [31:0] m_wdata = '0, m_exp = '0;
    logic [31:0] m_if_rd = '0, m_d_rd = '0;

    function automatic logic [31:0] model_read(logic [11:0] base,
                                               int n, bit sgn);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(shadow[(int'(base) + i) % 4096]) << (8 * i));
        if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_last_if = 1; m_t = 0;
            m_if_rd = '0; m_d_rd = '0;
        end else if (!m_busy) begin
            if (if_req || d_req) begin
                bit sg;
                m_is_if = if_req && (!d_req || !m_last_if);
                if (m_is_if) begin
                    m_we = 0; m_n = 4; sg = 0;
                    m_base = if_addr[11:0]; m_wdata = '0;
                end else begin
                    m_we = d_we; sg = d_sign;
                    m_base = d_addr[11:0]; m_wdata = d_wdata;
                    m_n = (d_length == 2'b01) ? 1 :
                          (d_length == 2'b10) ? 2 : 4;
                end
                m_exp = model_read(m_base, m_n, sg);
                m_t = 0;
                m_busy = 1;
            end
        end else begin
            int dt;
            dt = m_we ? m_n : m_n + 1;
            if (m_we && m_t < m_n)
                shadow[(int'(m_base) + m_t) % 4096] =
                    8'(m_wdata >> (8 * m_t));
            if (m_t == dt) begin
                m_busy = 0;
                m_last_if = m_is_if;
                if (!m_we) begin
                    if (m_is_if) m_if_rd = m_exp;
                    else         m_d_rd  = m_exp;
                end
            end else begin
                m_t++;
            end
        end
    end

    // per-cycle compare of every output against the model
    always @(negedge clk) begin : cmp
        int dt;
        bit iss, ind;
        dt  = m_we ? m_n : m_n + 1;
        iss = m_busy && (m_t < m_n);
        ind = m_busy && (m_t == dt);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("if_gnt", 32'(if_gnt), 32'(m_busy && m_is_if));
        chk("d_gnt", 32'(d_gnt), 32'(m_busy && !m_is_if));
        chk("mem_we", 32'(mem_we), 32'(iss && m_we));
        chk("mem_re", 32'(mem_re), 32'(iss && !m_we));
        chk("mem_addr", 32'(mem_addr),
            iss ? 32'((int'(m_base) + m_t) % 4096) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata),
            (iss && m_we) ? 32'(8'(m_wdata >> (8 * m_t))) : 32'd0);
        chk("if_done", 32'(if_done), 32'(ind && m_is_if));
        chk("d_done", 32'(d_done), 32'(ind && !m_is_if));
        chk("if_rdata", if_rdata,
            (ind && m_is_if) ? m_exp : m_if_rd);
        chk("d_rdata", d_rdata,
            (ind && !m_is_if && !m_we) ? m_exp : m_d_rd);
    end

    // ---------------- requester tasks ----------------
    task automatic d_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] len,
                        input logic sg, output logic [31:0] rd,
                        output int lat);
        @(negedge clk);
        d_we = we; d_addr = addr; d_wdata = wd;
        d_length = len; d_sign = sg; d_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_done && lat < 40);
        chk("d_op_done", 32'(d_done), 32'd1);
        rd = d_rdata;
        d_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] addr,
                         output logic [31:0] rd, output int lat);
        @(negedge clk);
        if_addr = addr; if_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_done && lat < 40);
        chk("if_op_done", 32'(if_done), 32'd1);
        rd = if_rdata;
        if_req = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0)
            a = 32'hFFC + 32'($urandom_range(0, 3));
        else
            a = 32'h100 + 32'($urandom_range(0, 63));
        return a | ($urandom & 32'hFFFF_F000);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        int lat, gcnt, run, maxrun, seen, mm;
        bit started, pd, pi;
        int gq [$];

        for (int i = 0; i < 4096; i++) begin
            ram[i] = init_byte(i);
            shadow[i] = init_byte(i);
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        #1 rst = 1'b0;

        d_op(1, 32'h010, 32'hDEADBEEF, 2'b00, 0, rd, lat);
        chk("st_word_lat", 32'(lat), 32'd5);
        chk("st_word_bytes", {ram[12'h013], ram[12'h012],
                              ram[12'h011], ram[12'h010]}, 32'hDEADBEEF);
        d_op(0, 32'h010, 32'h0, 2'b00, 0, rd, lat);
        chk("ld_word", rd, 32'hDEADBEEF);
        chk("ld_word_lat", 32'(lat), 32'd6);

        d_op(1, 32'h020, 32'h0000_0080, 2'b01, 0, rd, lat);
        chk("st_byte_lat", 32'(lat), 32'd2);
        d_op(0, 32'h020, 32'h0, 2'b01, 1, rd, lat);
        chk("ld_byte_s", rd, 32'hFFFFFF80);
        chk("ld_byte_s_lat", 32'(lat), 32'd3);
        d_op(0, 32'h020, 32'h0, 2'b01, 0, rd, lat);
        chk("ld_byte_u", rd, 32'h00000080);
        chk("ld_byte_u_lat", 32'(lat), 32'd3);

        d_op(1, 32'h030, 32'h0000_8001, 2'b10, 0, rd, lat);
        d_op(0, 32'h030, 32'h0, 2'b10, 1, rd, lat);
        chk("ld_half_s", rd, 32'hFFFF8001);
        d_op(0, 32'h030, 32'h0, 2'b10, 0, rd, lat);
        chk("ld_half_u", rd, 32'h00008001);
        chk("ld_half_lat", 32'(lat), 32'd4);

        if_op(32'h010, rd, lat);
        chk("fetch", rd, 32'hDEADBEEF);
        chk("fetch_lat", 32'(lat), 32'd6);

        d_op(1, 32'h0FFE, 32'h11223344, 2'b11, 0, rd, lat);
        chk("wrap_ffe", 32'(ram[12'hFFE]), 32'h44);
        chk("wrap_fff", 32'(ram[12'hFFF]), 32'h33);
        chk("wrap_000", 32'(ram[12'h000]), 32'h22);
        chk("wrap_001", 32'(ram[12'h001]), 32'h11);

        // both requesters held high from reset
        @(negedge clk);
        #1 rst = 1'b1;
        d_we = 0; d_addr = 32'h020; d_length = 2'b01; d_sign = 1;
        d_req = 1; if_addr = 32'h010; if_req = 1;
        @(negedge clk);
        #1 rst = 1'b0;
        started = 0; run = 0; maxrun = 0; pd = 0; pi = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (d_gnt && !pd) gq.push_back(0);
            if (if_gnt && !pi) gq.push_back(1);
            pd = d_gnt; pi = if_gnt;
            if (busy) started = 1;
            if (started && !busy) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        d_req = 0; if_req = 0;
        gcnt = gq.size();
        chk("tie_grant_count", 32'(gcnt >= 4), 32'd1);
        if (gcnt >= 4) begin
            chk("tie_g0_d", 32'(gq[0]), 32'd0);
            chk("tie_g1_if", 32'(gq[1]), 32'd1);
            chk("tie_g2_d", 32'(gq[2]), 32'd0);
            chk("tie_g3_if", 32'(gq[3]), 32'd1);
        end
        chk("tie_idle_gap", 32'(maxrun), 32'd1);
        repeat (20) @(negedge clk);

        // reset during the third byte of a word store
        d_we = 1; d_addr = 32'h040; d_wdata = 32'hA1B2C3D4;
        d_length = 2'b00; d_sign = 0; d_req = 1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        d_req = 0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gnt", 32'(d_gnt), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mid_rst_rdata", d_rdata, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (d_done) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        chk("mid_rst_b0", 32'(ram[12'h040]), 32'hD4);
        chk("mid_rst_b1", 32'(ram[12'h041]), 32'hC3);
        chk("mid_rst_b2", 32'(ram[12'h042]), 32'(init_byte(12'h042)));
        chk("mid_rst_b3", 32'(ram[12'h043]), 32'(init_byte(12'h043)));

        // random concurrent traffic from both requesters
        fork
            begin : drv_d
                int w, gap;
                for (int i = 0; i < 30; i++) begin
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = rnd_addr();
                    d_wdata = $urandom;
                    d_length = 2'($urandom_range(0, 3));
                    d_sign = 1'($urandom_range(0, 1));
                    d_req = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!d_done && w < 60);
                    chk("d_rand_done", 32'(d_done), 32'd1);
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        d_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                d_req = 1'b0;
            end
            begin : drv_if
                int w, gap;
                for (int i = 0; i < 30; i++) begin
                    if_addr = rnd_addr();
                    if_req = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!if_done && w < 60);
                    chk("if_rand_done", 32'(if_done), 32'd1);
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        if_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                if_req = 1'b0;
            end
        join
        repeat (5) @(negedge clk);

        mm = 0;
        for (int i = 0; i < 4096; i++)
            if (ram[i] !== shadow[i]) mm++;
        chk("ram_vs_model", 32'(mm), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
